// File: rtl/dmem_responder.sv
// Data-memory responder for a cache controller.
// Accepts one request at a time, waits LATENCY cycles, then either bursts a
// 4-word aligned line into rd_line (read) or commits one word (write), and
// pulses ready for one cycle in DONE before going back to IDLE.
module dmem_responder #(
  parameter int MEM_DEPTH  = 1024,
  parameter int LINE_WIDTH = 128,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [9:0]            req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  req_ack,
  output logic                  busy,
  output logic                  ready,
  output logic [LINE_WIDTH-1:0] rd_line
);

  localparam int AW = $clog2(MEM_DEPTH);

  // The down-counter reaches zero on the last WAIT cycle, so it starts at
  // LATENCY-1. With LATENCY=0 WAIT is skipped and the value is never used.
  localparam logic [3:0] WAIT_LOAD = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [3:0]    wait_cnt;
  logic [1:0]    beat;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          accept;

  logic [31:0]   mem [MEM_DEPTH];

  // Requests are only seen in IDLE; anything arriving while busy is dropped.
  assign accept = (state == IDLE) && req_valid;
  assign busy   = (state != IDLE);
  assign ready  = (state == DONE);

  // State register; reset aborts any request in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY > 0) begin
            state_next = WAIT;
          end else if (req_we) begin
            state_next = DONE;
          end else begin
            state_next = BURST;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = we_q ? DONE : BURST;
        end
      end
      BURST: begin
        if (beat == 2'd3) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, wait/beat counters, line assembly and the ack pulse.
  // The line base is the captured address with its low two bits replaced by
  // the beat number, so a read never wraps out of its aligned line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= 4'd0;
      beat     <= 2'd0;
      rd_line  <= '0;
      req_ack  <= 1'b0;
    end else begin
      req_ack <= accept;
      if (accept) begin
        we_q     <= req_we;
        addr_q   <= req_addr[AW-1:0];
        wdata_q  <= req_wdata;
        wait_cnt <= WAIT_LOAD;
        beat     <= 2'd0;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end else if (state == BURST) begin
        rd_line[{beat, 5'b0} +: 32] <= mem[{addr_q[AW-1:2], beat}];
        beat                        <= beat + 2'd1;
      end
    end
  end

  // Storage array has no reset; a write commits at the end of its DONE cycle,
  // so an aborted write never reaches memory.
  always_ff @(posedge clk) begin
    if (state == DONE && we_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=4 and a LATENCY=0
// instance share one set of stimulus; use_zero selects which one is checked.
module tb_dmem_responder;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_we = 1'b0;
  logic [9:0]   req_addr = '0;
  logic [31:0]  req_wdata = '0;

  logic         ack4, busy4, ready4;
  logic [127:0] line4;
  logic         ack0, busy0, ready0;
  logic [127:0] line0;

  logic         use_zero = 1'b0;
  logic         ack, busy, ready;
  logic [127:0] line;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic         we;
    logic [9:0]   addr;
    logic [31:0]  wdata;
    logic [127:0] exp_line;
  } vec_t;

  vec_t vecs4[18];
  vec_t vecs0[6];

  dmem_responder #(.MEM_DEPTH(1024), .LINE_WIDTH(128), .LATENCY(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(ack4),
    .busy(busy4), .ready(ready4), .rd_line(line4)
  );

  dmem_responder #(.MEM_DEPTH(1024), .LINE_WIDTH(128), .LATENCY(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(ack0),
    .busy(busy0), .ready(ready0), .rd_line(line0)
  );

  assign ack   = use_zero ? ack0   : ack4;
  assign busy  = use_zero ? busy0  : busy4;
  assign ready = use_zero ? ready0 : ready4;
  assign line  = use_zero ? line0  : line4;

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // One transaction: drive for one edge, then follow it to its ready pulse.
  task automatic apply_stimulus(input vec_t v);
    int c;
    int ack_count;
    int busy_drops;
    int line_changes;
    int exp_ready;
    logic first_ack;
    logic [127:0] start_line;
    exp_ready = (use_zero ? 0 : 4) + (v.we ? 1 : 5);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    start_line = line;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    c = 1;
    first_ack = ack;
    ack_count = 0;
    busy_drops = 0;
    line_changes = 0;
    while (1) begin
      if (ack) ack_count++;
      if (!busy) busy_drops++;
      if (line !== start_line) line_changes++;
      if (ready || c >= 40) break;
      @(posedge clk);
      #1;
      c++;
    end
    check_output("ack_first_cycle", 128'(first_ack), 128'(1));
    check_output("ack_count", 128'(ack_count), 128'(1));
    check_output("busy_held", 128'(busy_drops), 128'(0));
    check_output("ready_cycle", 128'(c), 128'(exp_ready));
    check_output("rd_line", line, v.exp_line);
    if (v.we) check_output("line_stable_on_write", 128'(line_changes), 128'(0));
    @(posedge clk);
    #1;
    check_output("idle_after_done", 128'({busy, ready, ack}), 128'(0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int c;
    int ack_count;
    int ready_count;
    int last_ack;
    int last_ready;

    vecs4[0]  = '{1'b1, 10'h010, 32'hDEADBEEF, 128'h0};
    vecs4[1]  = '{1'b1, 10'h020, 32'h11111111, 128'h0};
    vecs4[2]  = '{1'b1, 10'h021, 32'h22222222, 128'h0};
    vecs4[3]  = '{1'b1, 10'h022, 32'h33333333, 128'h0};
    vecs4[4]  = '{1'b1, 10'h023, 32'h44444444, 128'h0};
    vecs4[5]  = '{1'b0, 10'h022, 32'h0, 128'h44444444_33333333_22222222_11111111};
    vecs4[6]  = '{1'b1, 10'h021, 32'h55555555, 128'h44444444_33333333_22222222_11111111};
    vecs4[7]  = '{1'b0, 10'h020, 32'h0, 128'h44444444_33333333_55555555_11111111};
    vecs4[8]  = '{1'b1, 10'h3FC, 32'hA1A1A1A1, 128'h44444444_33333333_55555555_11111111};
    vecs4[9]  = '{1'b1, 10'h3FD, 32'hB2B2B2B2, 128'h44444444_33333333_55555555_11111111};
    vecs4[10] = '{1'b1, 10'h3FE, 32'hC3C3C3C3, 128'h44444444_33333333_55555555_11111111};
    vecs4[11] = '{1'b1, 10'h3FF, 32'hD4D4D4D4, 128'h44444444_33333333_55555555_11111111};
    vecs4[12] = '{1'b0, 10'h3FF, 32'h0, 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1};
    vecs4[13] = '{1'b1, 10'h100, 32'h12345678, 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1};
    vecs4[14] = '{1'b1, 10'h030, 32'h0, 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1};
    vecs4[15] = '{1'b1, 10'h031, 32'h0, 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1};
    vecs4[16] = '{1'b1, 10'h032, 32'h0, 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1};
    vecs4[17] = '{1'b1, 10'h033, 32'h0, 128'hD4D4D4D4_C3C3C3C3_B2B2B2B2_A1A1A1A1};

    vecs0[0] = '{1'b1, 10'h050, 32'h0BADF00D, 128'h0};
    vecs0[1] = '{1'b1, 10'h051, 32'h600D0001, 128'h0};
    vecs0[2] = '{1'b1, 10'h052, 32'h600D0002, 128'h0};
    vecs0[3] = '{1'b1, 10'h053, 32'h600D0003, 128'h0};
    vecs0[4] = '{1'b0, 10'h052, 32'h0, 128'h600D0003_600D0002_600D0001_0BADF00D};
    vecs0[5] = '{1'b1, 10'h051, 32'h77777777, 128'h600D0003_600D0002_600D0001_0BADF00D};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_outputs", 128'({ack, busy, ready}), 128'(0));
    check_output("reset_line", line, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven transactions on the LATENCY=4 instance
    for (int i = 0; i < 18; i++) apply_stimulus(vecs4[i]);

    // req_valid held high: one ack per transaction, one idle cycle between
    // ready and the next ack, everything else dropped
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'h040;
    req_wdata = 32'h0;
    ack_count = 0;
    ready_count = 0;
    last_ack = 0;
    last_ready = 0;
    for (c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (ack) begin
        ack_count++;
        if (ack_count > 1) check_output("stream_ack_gap", 128'(c - last_ready), 128'(2));
        last_ack = c;
      end
      if (ready) begin
        ready_count++;
        check_output("stream_ready_gap", 128'(c - last_ack), 128'(4));
        last_ready = c;
      end
      req_addr  = (c % 2 == 1) ? 10'h041 : 10'h040;
      req_wdata = 32'(c);
    end
    req_valid = 1'b0;
    req_we    = 1'b0;
    check_output("stream_ack_total", 128'(ack_count), 128'(5));
    check_output("stream_ready_total", 128'(ready_count), 128'(5));

    // Reset during WAIT of a write: outputs drop at once, write is lost
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 10'h030;
    req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    @(posedge clk);
    #1;
    check_output("abort_in_wait", 128'(busy), 128'(1));
    reset_n = 1'b0;
    #1;
    check_output("abort_outputs", 128'({ack, busy, ready}), 128'(0));
    check_output("abort_line", line, 128'h0);
    @(negedge clk);
    reset_n = 1'b1;
    ready_count = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (ready) ready_count++;
    end
    check_output("abort_no_ready", 128'(ready_count), 128'(0));
    apply_stimulus('{1'b0, 10'h030, 32'h0, 128'h0});

    // LATENCY=0 instance, starting from a clean rd_line
    pulse_reset();
    use_zero = 1'b1;
    for (int i = 0; i < 6; i++) apply_stimulus(vecs0[i]);
    apply_stimulus('{1'b0, 10'h050, 32'h0, 128'h600D0003_600D0002_77777777_0BADF00D});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
